// File: rtl/spart_core.sv
// SPART core: bus register file, programmable 16x baud generator,
// 8N1 transmitter and 8N1 receiver with an rxd synchronizer.
module spart_core #(
    parameter logic [15:0] DIV_RESET   = 16'h028A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Bus decode and combinational read mux
    logic              wr_c;
    logic              rd_rx_c;
    logic [DATA_W-1:0] rdata_c;
    logic [DATA_W-1:0] rx_buf;

    assign wr_c    = iocs & ~iorw;
    assign rd_rx_c = iocs & iorw & (ioaddr == 2'b00);

    always_comb begin
        rdata_c = '0;
        case (ioaddr)
            2'b00:   rdata_c = rx_buf;
            2'b01:   rdata_c = {6'b0, tbr, rda};
            default: rdata_c = '0;
        endcase
    end

    assign databus = (iocs & iorw) ? rdata_c : 8'hzz;

    // Baud generator: tick when the down-counter hits zero, then reload
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] bcnt_q, bcnt_d;
    logic             tick_c;
    logic             div_wr_c;

    always_comb begin
        div_d    = div_q;
        div_wr_c = 1'b0;
        if (wr_c && ioaddr == 2'b10) begin
            div_d[7:0] = databus;
            div_wr_c   = 1'b1;
        end
        if (wr_c && ioaddr == 2'b11) begin
            div_d[15:8] = databus;
            div_wr_c    = 1'b1;
        end
        tick_c = (bcnt_q == '0);
        if (div_wr_c) begin
            bcnt_d = div_d;
        end else if (tick_c) begin
            bcnt_d = div_q;
        end else begin
            bcnt_d = bcnt_q - DIV_W'(1);
        end
    end

    // Transmitter next-state logic; a latched byte waits for a tick boundary
    state_t            tx_q, tx_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic              tx_pend_q, tx_pend_d;
    logic              txd_d, tbr_d;
    logic              tx_wr_c;

    assign tx_wr_c = wr_c & (ioaddr == 2'b00) & tbr;

    always_comb begin
        tx_d      = tx_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_pend_d = tx_pend_q;
        txd_d     = txd;
        tbr_d     = tbr;
        case (tx_q)
            IDLE: begin
                if (tx_wr_c) begin
                    tx_sh_d   = databus;
                    tx_pend_d = 1'b1;
                    tbr_d     = 1'b0;
                end else if (tx_pend_q && tick_c) begin
                    tx_d      = START;
                    tx_pend_d = 1'b0;
                    tx_cnt_d  = '0;
                    txd_d     = 1'b0;
                end
            end
            START: begin
                if (tick_c) begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    if (tx_cnt_q == CNT_W'(15)) begin
                        tx_d     = DATA;
                        tx_bit_d = '0;
                        txd_d    = tx_sh_q[0];
                        tx_sh_d  = tx_sh_q >> 1;
                    end
                end
            end
            DATA: begin
                if (tick_c) begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    if (tx_cnt_q == CNT_W'(15)) begin
                        if (tx_bit_q == BIT_W'(7)) begin
                            tx_d  = STOP;
                            txd_d = 1'b1;
                        end else begin
                            tx_bit_d = tx_bit_q + BIT_W'(1);
                            txd_d    = tx_sh_q[0];
                            tx_sh_d  = tx_sh_q >> 1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick_c) begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    if (tx_cnt_q == CNT_W'(15)) begin
                        tx_d  = IDLE;
                        tbr_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Receiver next-state logic; samples mid-bit from the start-edge reference
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs_c;
    logic                   rx_prev_q;
    state_t                 rx_q, rx_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0]      rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]      rx_buf_d;
    logic                   rda_d;
    logic                   rx_set_c;

    assign rxs_c = sync_q[SYNC_STAGES-1];

    always_comb begin
        rx_d     = rx_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_set_c = 1'b0;
        case (rx_q)
            IDLE: begin
                if (rx_prev_q && !rxs_c) begin
                    rx_d     = START;
                    rx_cnt_d = '0;
                end
            end
            START: begin
                if (tick_c) begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    if (rx_cnt_q == CNT_W'(7)) begin
                        if (rxs_c) begin
                            rx_d = IDLE;
                        end else begin
                            rx_d     = DATA;
                            rx_cnt_d = '0;
                            rx_bit_d = '0;
                        end
                    end
                end
            end
            DATA: begin
                if (tick_c) begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    if (rx_cnt_q == CNT_W'(15)) begin
                        rx_sh_d = {rxs_c, rx_sh_q[DATA_W-1:1]};
                        if (rx_bit_q == BIT_W'(7)) begin
                            rx_d = STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + BIT_W'(1);
                        end
                    end
                end
            end
            STOP: begin
                if (tick_c) begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    if (rx_cnt_q == CNT_W'(15)) begin
                        rx_d     = IDLE;
                        rx_set_c = rxs_c;
                    end
                end
            end
        endcase
        rx_buf_d = rx_set_c ? rx_sh_q : rx_buf;
        // A completing frame takes priority over a concurrent buffer read
        if (rx_set_c) begin
            rda_d = 1'b1;
        end else if (rd_rx_c) begin
            rda_d = 1'b0;
        end else begin
            rda_d = rda;
        end
    end

    // All state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= DIV_RESET;
            bcnt_q    <= '0;
            tx_q      <= IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_pend_q <= 1'b0;
            txd       <= 1'b1;
            tbr       <= 1'b1;
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            rx_q      <= IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_buf    <= '0;
            rda       <= 1'b0;
        end else begin
            div_q     <= div_d;
            bcnt_q    <= bcnt_d;
            tx_q      <= tx_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_pend_q <= tx_pend_d;
            txd       <= txd_d;
            tbr       <= tbr_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rxd};
            rx_prev_q <= rxs_c;
            rx_q      <= rx_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_buf    <= rx_buf_d;
            rda       <= rda_d;
        end
    end

endmodule
